// File: rtl/w_grf_writeback.sv
// W-stage write-back: selects the write-back value, gates the write,
// commits to the 32x32 general register file, serves two D-stage read
// ports with same-cycle write-through, and keeps a retire trace/counter.
module w_grf_writeback #(
  parameter int unsigned NREG     = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_C,
  input  logic [31:0] W_DR,
  input  logic [31:0] W_PC8,
  input  logic [31:0] W_HILO,
  input  logic [31:0] W_PC,
  input  logic [4:0]  W_A3,
  input  logic [1:0]  W_WDSel,
  input  logic        W_RegWrite,
  input  logic        W_CondWr,
  input  logic        W_Cndtn,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  output logic [31:0] D_RD1,
  output logic [31:0] D_RD2,
  output logic [31:0] W_WD,
  output logic        W_WE,
  output logic        tr_valid,
  output logic [31:0] tr_pc,
  output logic [4:0]  tr_a3,
  output logic [31:0] tr_wd,
  output logic [31:0] retire_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;
  localparam logic [1:0] SEL_HILO = 2'd3;

  logic [XLEN-1:0] regs [NREG];

  // Write-back data select.
  always_comb begin
    W_WD = W_C;
    case (W_WDSel)
      SEL_ALU:  W_WD = W_C;
      SEL_LOAD: W_WD = W_DR;
      SEL_LINK: W_WD = W_PC8;
      SEL_HILO: W_WD = W_HILO;
      default:  W_WD = W_C;
    endcase
  end

  // Effective write: r0 is never a target, a failed condition cancels the write.
  assign W_WE = W_RegWrite & (W_A3 != AW'(0)) & (~W_CondWr | W_Cndtn);

  // Register file storage; r0 stays zero because W_WE excludes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (W_WE) begin
      regs[W_A3] <= W_WD;
    end
  end

  // Read port 1 with write-through bypass.
  always_comb begin
    D_RD1 = '0;
    if (D_A1 == AW'(0))             D_RD1 = '0;
    else if (W_WE && D_A1 == W_A3)  D_RD1 = W_WD;
    else                            D_RD1 = regs[D_A1];
  end

  // Read port 2 with write-through bypass.
  always_comb begin
    D_RD2 = '0;
    if (D_A2 == AW'(0))             D_RD2 = '0;
    else if (W_WE && D_A2 == W_A3)  D_RD2 = W_WD;
    else                            D_RD2 = regs[D_A2];
  end

  // Retire trace: pulse valid on a commit, hold the payload otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tr_valid <= 1'b0;
      tr_pc    <= PC_RESET;
      tr_a3    <= '0;
      tr_wd    <= '0;
    end else begin
      tr_valid <= W_WE;
      if (W_WE) begin
        tr_pc <= W_PC;
        tr_a3 <= W_A3;
        tr_wd <= W_WD;
      end
    end
  end

  // Retire counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    retire_cnt <= '0;
    else if (W_WE) retire_cnt <= retire_cnt + XLEN'(1);
  end

endmodule

// File: tb/tb_w_grf_writeback.sv
module tb_w_grf_writeback;

  logic        clk;
  logic        reset;
  logic [31:0] W_C, W_DR, W_PC8, W_HILO, W_PC;
  logic [4:0]  W_A3;
  logic [1:0]  W_WDSel;
  logic        W_RegWrite, W_CondWr, W_Cndtn;
  logic [4:0]  D_A1, D_A2;
  logic [31:0] D_RD1, D_RD2, W_WD;
  logic        W_WE;
  logic        tr_valid;
  logic [31:0] tr_pc;
  logic [4:0]  tr_a3;
  logic [31:0] tr_wd;
  logic [31:0] retire_cnt;

  w_grf_writeback dut (
    .clk(clk), .reset(reset),
    .W_C(W_C), .W_DR(W_DR), .W_PC8(W_PC8), .W_HILO(W_HILO), .W_PC(W_PC),
    .W_A3(W_A3), .W_WDSel(W_WDSel), .W_RegWrite(W_RegWrite),
    .W_CondWr(W_CondWr), .W_Cndtn(W_Cndtn),
    .D_A1(D_A1), .D_A2(D_A2), .D_RD1(D_RD1), .D_RD2(D_RD2),
    .W_WD(W_WD), .W_WE(W_WE),
    .tr_valid(tr_valid), .tr_pc(tr_pc), .tr_a3(tr_a3), .tr_wd(tr_wd),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1, rd2, wd;
    logic        we;
    logic        trv;
    logic [31:0] trpc;
    logic [4:0]  tra3;
    logic [31:0] trwd, cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: architectural state as plain arrays/scalars.
  logic [31:0] m_regs [32];
  logic        m_trv;
  logic [31:0] m_trpc, m_trwd, m_cnt;
  logic [4:0]  m_tra3;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_trv = 1'b0; m_trpc = 32'h0000_3000; m_tra3 = 5'd0; m_trwd = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive mid-cycle, push expectations, then advance the model past the next edge.
  task automatic do_cycle(input logic rst, input logic [31:0] c, dr, pc8, hilo, pc,
                          input logic [4:0] a3, input logic [1:0] sel,
                          input logic rw, cw, cn, input logic [4:0] a1, a2);
    exp_t e;
    logic [31:0] wd;
    logic        we;
    @(posedge clk); #2;
    reset = rst; W_C = c; W_DR = dr; W_PC8 = pc8; W_HILO = hilo; W_PC = pc;
    W_A3 = a3; W_WDSel = sel; W_RegWrite = rw; W_CondWr = cw; W_Cndtn = cn;
    D_A1 = a1; D_A2 = a2;
    if (!rst) model_reset();
    wd = (sel == 2'd0) ? c : (sel == 2'd1) ? dr : (sel == 2'd2) ? pc8 : hilo;
    we = rw && (a3 != 5'd0) && (!cw || cn);
    e.wd   = wd;
    e.we   = we;
    e.rd1  = (a1 == 5'd0) ? 32'h0 : (we && a1 == a3) ? wd : m_regs[a1];
    e.rd2  = (a2 == 5'd0) ? 32'h0 : (we && a2 == a3) ? wd : m_regs[a2];
    e.trv  = m_trv; e.trpc = m_trpc; e.tra3 = m_tra3; e.trwd = m_trwd; e.cnt = m_cnt;
    q.push_back(e);
    if (rst) begin
      m_trv = we;
      if (we) begin
        m_regs[a3] = wd; m_trpc = pc; m_tra3 = a3; m_trwd = wd; m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic idle_read(input logic [4:0] a1, a2);
    do_cycle(1'b1, 0, 0, 0, 0, 0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, a1, a2);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("D_RD1", D_RD1, e.rd1);
      chk("D_RD2", D_RD2, e.rd2);
      chk("W_WD", W_WD, e.wd);
      chk("W_WE", 32'(W_WE), 32'(e.we));
      chk("tr_valid", 32'(tr_valid), 32'(e.trv));
      chk("tr_pc", tr_pc, e.trpc);
      chk("tr_a3", 32'(tr_a3), 32'(e.tra3));
      chk("tr_wd", tr_wd, e.trwd);
      chk("retire_cnt", retire_cnt, e.cnt);
    end
  end

  initial begin
    reset = 1'b0; W_C = 0; W_DR = 0; W_PC8 = 0; W_HILO = 0; W_PC = 0;
    W_A3 = 0; W_WDSel = 0; W_RegWrite = 0; W_CondWr = 0; W_Cndtn = 0; D_A1 = 0; D_A2 = 0;
    model_reset();

    // Reset state.
    do_cycle(1'b0, 0, 0, 0, 0, 0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd7);
    do_cycle(1'b0, 0, 0, 0, 0, 0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd31);
    // Release with a write to r5, both ports bypass.
    do_cycle(1'b1, 32'h1234_5678, 0, 0, 0, 32'h0000_3000, 5'd5, 2'd0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5);
    idle_read(5'd5, 5'd0);
    // Write to r0 dropped.
    do_cycle(1'b1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0000_3004, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5);
    idle_read(5'd0, 5'd5);
    // Conditional link write: condition false, then true.
    do_cycle(1'b1, 0, 0, 32'h3008, 0, 32'h0000_3000, 5'd31, 2'd2, 1'b1, 1'b1, 1'b0, 5'd31, 5'd5);
    idle_read(5'd31, 5'd31);
    do_cycle(1'b1, 0, 0, 32'h3008, 0, 32'h0000_3010, 5'd31, 2'd2, 1'b1, 1'b1, 1'b1, 5'd31, 5'd31);
    idle_read(5'd31, 5'd5);
    // Select sweep into r1..r4.
    for (int s = 0; s < 4; s++)
      do_cycle(1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000_3100 + 32'(s * 4),
               5'(s + 1), 2'(s), 1'b1, 1'b0, 1'b0, 5'(s + 1), 5'd31);
    idle_read(5'd1, 5'd2);
    idle_read(5'd3, 5'd4);

    // Randomized traffic with occasional mid-stream reset.
    for (int n = 0; n < 400; n++) begin
      logic rst;
      rst = ($urandom_range(0, 49) != 0);
      do_cycle(rst, $urandom, $urandom, $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
               rst && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Several writes, then a reset asserted between edges.
    for (int k = 1; k <= 3; k++)
      do_cycle(1'b1, 32'hA000_0000 + 32'(k), 0, 0, 0, 32'h0000_4000 + 32'(k * 4),
               5'(k + 8), 2'd0, 1'b1, 1'b0, 1'b0, 5'(k + 8), 5'd0);
    do_cycle(1'b0, 0, 0, 0, 0, 0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd11);
    // First commit after reset behaves normally.
    do_cycle(1'b1, 32'h5555_AAAA, 0, 0, 0, 32'h0000_5000, 5'd7, 2'd0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd9);
    idle_read(5'd7, 5'd10);

    // Drain with a bounded wait.
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
